aes_block_serializer: RTL and testbench
=======================================

# aes_block_serializer

Output-side reader for the AES datapath. It accepts one 128-bit state block from the final pipeline stage through a valid/ready handshake. It then streams that block out as 32-bit words, most significant word first, to the host-facing result interface. It converts the block-wide pipeline domain into the narrow word stream without losing or duplicating blocks under arbitrary downstream back-pressure.

## Interface
- BLOCK_W, 128, block width in bits; must equal NUM_WORDS*WORD_W.
- WORD_W, 32, output word width in bits.
- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- blk_data_i  input  BLOCK_W  block from the last pipeline stage. Bits [127:120] are AES byte 0.
- blk_valid_i  input  1  blk_data_i holds a valid block.
- blk_ready_o  output  1  the serializer can accept a block this cycle.
- word_data_o  output  WORD_W  current output word.
- word_valid_o  output  1  word_data_o is valid.
- word_ready_i  input  1  the downstream block accepts word_data_o.
- word_last_o  output  1  only with AES_SER_LAST_EN; marks the final word of a block.

## Operation
- A block transfer occurs when blk_valid_i && blk_ready_o. A word transfer occurs when word_valid_o && word_ready_i.
- The block has two states: IDLE and SEND.
- **IDLE**
  - word_valid_o=0 and blk_ready_o=1.
  - On a block transfer: load shift register sr<=blk_data_i and word counter cnt<=0, then go to SEND.
- **SEND**
  - word_valid_o=1 and word_data_o=sr[BLOCK_W-1 -: WORD_W].
  - On a word transfer with cnt<NUM_WORDS-1: shift sr left by WORD_W (zero fill) and set cnt<=cnt+1.
  - On a word transfer with cnt==NUM_WORDS-1 (the last word):
    - If blk_valid_i is also high, this is a simultaneous block transfer: load the new block, set cnt<=0 and stay in SEND.
    - Otherwise go to IDLE.
- blk_ready_o = (state==IDLE) || (state==SEND && cnt==NUM_WORDS-1 && word_ready_i). This is a combinational path from word_ready_i.
- Back-pressure:
  - While word_valid_o=1 and word_ready_i=0, word_data_o, cnt and sr hold unchanged.
  - word_valid_o never drops before its word transfers.
- Block transfers are ignored while blk_ready_o=0. The upstream holds blk_data_i and blk_valid_i until accepted.
- cnt is $clog2(NUM_WORDS) bits wide. It never wraps by increment: the last-word condition always reloads it or leaves SEND.

## Timing
- Latency: a block accepted at rising edge N presents word 0 on word_data_o from edge N onward, i.e. in the cycle following the transfer.
- Throughput:
  - With word_ready_i held at 1, one word per cycle and one block every NUM_WORDS cycles, with no bubble between blocks.
  - If the next block is not presented until after its predecessor's last word, there is a one-cycle IDLE gap.
- Reset (asynchronous, immediate on assertion) sets:
  - state=IDLE, cnt=0, sr=0.
  - Outputs: word_valid_o=0, word_data_o=0, blk_ready_o=1, word_last_o=0.
  - Block transfers presented while reset is high are not captured.
- Reset mid-block discards the remaining words. The first word after release belongs to the next block accepted.

## Configuration
- AES_SER_LAST_EN:
  - Defined: the port word_last_o exists and word_last_o = (state==SEND && cnt==NUM_WORDS-1).
  - Undefined: the port is absent. All other behaviour is identical.

## Structure
- Shared package aes_pkg holds:
  - constants BLOCK_W=128, WORD_W=32 and NUM_WORDS=BLOCK_W/WORD_W;
  - typedef ser_state_t {IDLE, SEND}.
- No sub-module. The shift register, counter and FSM are small enough for a single module.

## Test plan
- **Single block, word_ready_i=1.** Block 0x00112233_44556677_8899AABB_CCDDEEFF produces words 00112233, 44556677, 8899AABB, CCDDEEFF on four consecutive cycles. With the macro defined, word_last_o=1 only on CCDDEEFF.
- **Back-pressure.** Same block; drop word_ready_i for 3 cycles while word 1 is shown. 44556677 is held stable with word_valid_o=1, and the four words still arrive in order.
- **Back-to-back blocks.** 0x...FF then 0xFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFF11 presented continuously, word_ready_i=1. Eight words arrive on eight consecutive cycles. blk_ready_o=1 only on the last-word cycles.
- **Upstream stall.** blk_valid_i=1 while in SEND at cnt=1. blk_ready_o=0 and no capture occurs. Capture happens on the last-word transfer.
- **Reset mid-block.** Assert reset after word 1 of block A. word_valid_o=0 immediately. After release, block B's word 0 is the first output, with no leftover word from A.

Source files
------------

// File: rtl/aes_pkg.sv
// ============================================================================
// Module   : aes_pkg
// Purpose  : Shared constants and types for the AES block serializer.
//            BLOCK_W   - block width in bits
//            WORD_W    - output word width in bits
//            NUM_WORDS - words per block
//            CNT_W     - word counter width
//            ser_state_t - serializer FSM state encoding
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package aes_pkg;

    localparam int BLOCK_W   = 128;
    localparam int WORD_W    = 32;
    localparam int NUM_WORDS = BLOCK_W / WORD_W;
    localparam int CNT_W     = $clog2(NUM_WORDS);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } ser_state_t;

endpackage : aes_pkg

`default_nettype wire

// File: rtl/aes_block_serializer_if.sv
// ============================================================================
// Module   : aes_block_serializer_if
// Purpose  : Block-in / word-out handshake bundle for aes_block_serializer.
//            blk_data_i/blk_valid_i/blk_ready_o : 128-bit block input side
//            word_data_o/word_valid_o/word_ready_i : 32-bit word output side
//            word_last_o : last-word marker, present with AES_SER_LAST_EN
//            modport slave  : serializer view
//            modport master : environment (upstream + downstream) view
// Macro    : AES_SER_LAST_EN
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface aes_block_serializer_if;
    import aes_pkg::*;

    logic [BLOCK_W-1:0] blk_data_i;
    logic               blk_valid_i;
    logic               blk_ready_o;
    logic [WORD_W-1:0]  word_data_o;
    logic               word_valid_o;
    logic               word_ready_i;
`ifdef AES_SER_LAST_EN
    logic               word_last_o;
`endif

    modport slave (
        input  blk_data_i,
        input  blk_valid_i,
        output blk_ready_o,
        output word_data_o,
        output word_valid_o,
`ifdef AES_SER_LAST_EN
        output word_last_o,
`endif
        input  word_ready_i
    );

    modport master (
        output blk_data_i,
        output blk_valid_i,
        input  blk_ready_o,
        input  word_data_o,
        input  word_valid_o,
`ifdef AES_SER_LAST_EN
        input  word_last_o,
`endif
        output word_ready_i
    );

endinterface : aes_block_serializer_if

`default_nettype wire

// File: rtl/aes_block_serializer.sv
// ============================================================================
// Module   : aes_block_serializer
// Purpose  : Accepts one 128-bit AES state block and streams it out as four
//            32-bit words, most significant word first, tolerating arbitrary
//            downstream back-pressure without loss or duplication.
// Ports    : clk   - clock, rising edge
//            reset - asynchronous active-high reset
//            bus   - aes_block_serializer_if.slave (block in, word out)
// Macro    : AES_SER_LAST_EN - adds word_last_o marking a block's final word
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module aes_block_serializer
    import aes_pkg::*;
(
    input  wire                      clk,
    input  wire                      reset,
    aes_block_serializer_if.slave    bus
);

    localparam logic [CNT_W-1:0] c_LAST_CNT = CNT_W'(NUM_WORDS - 1);

    ser_state_t         r_state;
    ser_state_t         w_state_next;
    logic [BLOCK_W-1:0] r_sr;
    logic [CNT_W-1:0]   r_cnt;

    logic               w_last;
    logic               w_blk_ready;
    logic               w_load;
    logic               w_shift;

    assign w_last = (r_cnt == c_LAST_CNT);

    // Ready is combinational from word_ready_i so the next block can be
    // taken on the same edge the last word leaves: no bubble between blocks.
    assign w_blk_ready = (r_state == IDLE) ||
                         ((r_state == SEND) && w_last && bus.word_ready_i);

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and datapath controls
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_shift      = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.blk_valid_i) begin
                    w_load       = 1'b1;
                    w_state_next = SEND;
                end
            end
            SEND: begin
                if (bus.word_ready_i) begin
                    if (!w_last) begin
                        w_shift = 1'b1;
                    end else if (bus.blk_valid_i) begin
                        w_load = 1'b1;
                    end else begin
                        w_state_next = IDLE;
                    end
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Shift register and word counter; hold when neither load nor shift
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sr  <= '0;
            r_cnt <= '0;
        end else if (w_load) begin
            r_sr  <= bus.blk_data_i;
            r_cnt <= '0;
        end else if (w_shift) begin
            r_sr  <= {r_sr[BLOCK_W-WORD_W-1:0], {WORD_W{1'b0}}};
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign bus.blk_ready_o  = w_blk_ready;
    assign bus.word_valid_o = (r_state == SEND);
    assign bus.word_data_o  = r_sr[BLOCK_W-1 -: WORD_W];
`ifdef AES_SER_LAST_EN
    assign bus.word_last_o  = (r_state == SEND) && w_last;
`endif

endmodule : aes_block_serializer

`default_nettype wire

// File: tb/tb_aes_block_serializer.sv
// ============================================================================
// Module   : tb_aes_block_serializer
// Purpose  : Directed self-checking bench for aes_block_serializer.
// Macro    : AES_SER_LAST_EN - also checks word_last_o when defined
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_aes_block_serializer;
    import aes_pkg::*;

    logic clk;
    logic reset;
    int   errors;
    int   checks;

    aes_block_serializer_if bus ();

    aes_block_serializer u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    localparam logic [127:0] c_BLK_A = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    localparam logic [127:0] c_BLK_B = 128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFF11;

    logic [31:0] exp_a [4];
    logic [31:0] exp_b [4];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset            = 1'b1;
        bus.blk_data_i   = c_BLK_A;
        bus.blk_valid_i  = 1'b1;
        bus.word_ready_i = 1'b1;
        tick();
        tick();
        checks++;
        if (bus.word_valid_o !== 1'b0) begin
            errors++; $display("FAIL reset_valid: got %b want 0", bus.word_valid_o);
        end
        checks++;
        if (bus.word_data_o !== 32'h0) begin
            errors++; $display("FAIL reset_data: got %h want 00000000", bus.word_data_o);
        end
        checks++;
        if (bus.blk_ready_o !== 1'b1) begin
            errors++; $display("FAIL reset_ready: got %b want 1", bus.blk_ready_o);
        end
`ifdef AES_SER_LAST_EN
        checks++;
        if (bus.word_last_o !== 1'b0) begin
            errors++; $display("FAIL reset_last: got %b want 0", bus.word_last_o);
        end
`endif
        reset           = 1'b0;
        bus.blk_valid_i = 1'b0;
        tick();
        checks++;
        if (bus.word_valid_o !== 1'b0) begin
            errors++; $display("FAIL reset_no_capture: got valid %b want 0", bus.word_valid_o);
        end
    endtask

    task automatic test_single;
        bus.blk_data_i   = c_BLK_A;
        bus.blk_valid_i  = 1'b1;
        bus.word_ready_i = 1'b1;
        #1;
        checks++;
        if (bus.blk_ready_o !== 1'b1) begin
            errors++; $display("FAIL single_idle_ready: got %b want 1", bus.blk_ready_o);
        end
        tick();
        bus.blk_valid_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (bus.word_valid_o !== 1'b1 || bus.word_data_o !== exp_a[i]) begin
                errors++;
                $display("FAIL single_word%0d: got v=%b d=%h want v=1 d=%h",
                         i, bus.word_valid_o, bus.word_data_o, exp_a[i]);
            end
`ifdef AES_SER_LAST_EN
            checks++;
            if (bus.word_last_o !== (i == 3)) begin
                errors++; $display("FAIL single_last%0d: got %b want %b", i, bus.word_last_o, (i == 3));
            end
`endif
            tick();
        end
        checks++;
        if (bus.word_valid_o !== 1'b0) begin
            errors++; $display("FAIL single_idle_after: got valid %b want 0", bus.word_valid_o);
        end
    endtask

    task automatic test_backpressure;
        bus.blk_data_i   = c_BLK_A;
        bus.blk_valid_i  = 1'b1;
        bus.word_ready_i = 1'b1;
        tick();
        bus.blk_valid_i = 1'b0;
        tick();
        checks++;
        if (bus.word_data_o !== exp_a[1]) begin
            errors++; $display("FAIL bp_word1: got %h want %h", bus.word_data_o, exp_a[1]);
        end
        bus.word_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (bus.word_valid_o !== 1'b1 || bus.word_data_o !== exp_a[1]) begin
                errors++;
                $display("FAIL bp_hold%0d: got v=%b d=%h want v=1 d=%h",
                         i, bus.word_valid_o, bus.word_data_o, exp_a[1]);
            end
        end
        bus.word_ready_i = 1'b1;
        for (int i = 1; i < 4; i++) begin
            checks++;
            if (bus.word_valid_o !== 1'b1 || bus.word_data_o !== exp_a[i]) begin
                errors++;
                $display("FAIL bp_order%0d: got v=%b d=%h want v=1 d=%h",
                         i, bus.word_valid_o, bus.word_data_o, exp_a[i]);
            end
            tick();
        end
        checks++;
        if (bus.word_valid_o !== 1'b0) begin
            errors++; $display("FAIL bp_idle_after: got valid %b want 0", bus.word_valid_o);
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] w_exp;
        bus.blk_data_i   = c_BLK_A;
        bus.blk_valid_i  = 1'b1;
        bus.word_ready_i = 1'b1;
        tick();
        bus.blk_data_i = c_BLK_B;
        for (int i = 0; i < 8; i++) begin
            w_exp = (i < 4) ? exp_a[i] : exp_b[i-4];
            checks++;
            if (bus.word_valid_o !== 1'b1 || bus.word_data_o !== w_exp) begin
                errors++;
                $display("FAIL b2b_word%0d: got v=%b d=%h want v=1 d=%h",
                         i, bus.word_valid_o, bus.word_data_o, w_exp);
            end
            checks++;
            if (bus.blk_ready_o !== (i == 3 || i == 7)) begin
                errors++;
                $display("FAIL b2b_ready%0d: got %b want %b", i, bus.blk_ready_o, (i == 3 || i == 7));
            end
            tick();
            if (i == 3) begin
                bus.blk_valid_i = 1'b0;
                #1;
            end
        end
        checks++;
        if (bus.word_valid_o !== 1'b0) begin
            errors++; $display("FAIL b2b_idle_after: got valid %b want 0", bus.word_valid_o);
        end
    endtask

    task automatic test_upstream_stall;
        bus.blk_data_i   = c_BLK_A;
        bus.blk_valid_i  = 1'b1;
        bus.word_ready_i = 1'b1;
        tick();
        bus.blk_valid_i = 1'b0;
        tick();
        // cnt=1: new block offered but must not be taken
        bus.blk_data_i  = c_BLK_B;
        bus.blk_valid_i = 1'b1;
        #1;
        checks++;
        if (bus.blk_ready_o !== 1'b0) begin
            errors++; $display("FAIL stall_ready_cnt1: got %b want 0", bus.blk_ready_o);
        end
        tick();
        checks++;
        if (bus.word_data_o !== exp_a[2] || bus.blk_ready_o !== 1'b0) begin
            errors++;
            $display("FAIL stall_cnt2: got d=%h r=%b want d=%h r=0",
                     bus.word_data_o, bus.blk_ready_o, exp_a[2]);
        end
        tick();
        // last word with downstream stalled: still not ready
        bus.word_ready_i = 1'b0;
        #1;
        checks++;
        if (bus.blk_ready_o !== 1'b0 || bus.word_data_o !== exp_a[3]) begin
            errors++;
            $display("FAIL stall_last_bp: got d=%h r=%b want d=%h r=0",
                     bus.word_data_o, bus.blk_ready_o, exp_a[3]);
        end
        tick();
        bus.word_ready_i = 1'b1;
        #1;
        checks++;
        if (bus.blk_ready_o !== 1'b1 || bus.word_data_o !== exp_a[3]) begin
            errors++;
            $display("FAIL stall_last_ready: got d=%h r=%b want d=%h r=1",
                     bus.word_data_o, bus.blk_ready_o, exp_a[3]);
        end
        tick();
        bus.blk_valid_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (bus.word_valid_o !== 1'b1 || bus.word_data_o !== exp_b[i]) begin
                errors++;
                $display("FAIL stall_b_word%0d: got v=%b d=%h want v=1 d=%h",
                         i, bus.word_valid_o, bus.word_data_o, exp_b[i]);
            end
            tick();
        end
        checks++;
        if (bus.word_valid_o !== 1'b0) begin
            errors++; $display("FAIL stall_idle_after: got valid %b want 0", bus.word_valid_o);
        end
    endtask

    task automatic test_reset_mid_block;
        bus.blk_data_i   = c_BLK_A;
        bus.blk_valid_i  = 1'b1;
        bus.word_ready_i = 1'b1;
        tick();
        bus.blk_valid_i = 1'b0;
        tick();
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (bus.word_valid_o !== 1'b0 || bus.word_data_o !== 32'h0 || bus.blk_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL midrst_async: got v=%b d=%h r=%b want v=0 d=00000000 r=1",
                     bus.word_valid_o, bus.word_data_o, bus.blk_ready_o);
        end
        tick();
        reset           = 1'b0;
        bus.blk_data_i  = c_BLK_B;
        bus.blk_valid_i = 1'b1;
        tick();
        bus.blk_valid_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (bus.word_valid_o !== 1'b1 || bus.word_data_o !== exp_b[i]) begin
                errors++;
                $display("FAIL midrst_b_word%0d: got v=%b d=%h want v=1 d=%h",
                         i, bus.word_valid_o, bus.word_data_o, exp_b[i]);
            end
            tick();
        end
        checks++;
        if (bus.word_valid_o !== 1'b0) begin
            errors++; $display("FAIL midrst_idle_after: got valid %b want 0", bus.word_valid_o);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        exp_a[0] = 32'h00112233; exp_a[1] = 32'h44556677;
        exp_a[2] = 32'h8899AABB; exp_a[3] = 32'hCCDDEEFF;
        exp_b[0] = 32'hFFFFFFFF; exp_b[1] = 32'hFFFFFFFF;
        exp_b[2] = 32'hFFFFFFFF; exp_b[3] = 32'hFFFFFF11;
        reset            = 1'b1;
        bus.blk_data_i   = '0;
        bus.blk_valid_i  = 1'b0;
        bus.word_ready_i = 1'b0;

        test_reset();
        test_single();
        test_backpressure();
        test_back_to_back();
        test_upstream_stall();
        test_reset_mid_block();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_aes_block_serializer

`default_nettype wire
